sd_card_read_ctrl: RTL and testbench

Single-block read controller for an SPI-mode SD card. It issues a CMD17 read through the companion command engine `sd_card_cmd`, then hunts for the 0xFE start token in the MISO bit stream. It deserialises 512 data bytes and writes each one to a byte-wide memory port. It sits between the host logic that requests sectors and the sector buffer memory.

---
 rtl/sd_card_read_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sd_card_read_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_read_ctrl.sv
// -----------------------------------------------------------------------------
// sd_card_read_ctrl
//
// Single-block (512-byte) read controller for an SPI-mode SD card. A start
// request latches the sector address and asks the companion command engine
// (sd_card_cmd) to issue CMD17. Once R1 comes back clean, the controller hunts
// for the 0xFE start token in the MISO shift window at every bit position. It
// then deserialises 512 bytes onto a byte-wide write port, drops the 16-bit
// CRC and reports completion.
//
// Ports
//   i_clk              system clock, also the SD bit clock (one MISO bit/cycle)
//   i_rst_n            synchronous active-low reset
//   i_start_read       single-cycle read request, honoured only when idle
//   i_addr             sector address, sent unchanged as the CMD17 argument
//   i_accept_register  MISO shift window, newest bit in [0]
//   o_status           0x01 busy, 0x02 done, 0x04 bad R1, 0x08 token timeout
//   o_data/o_addr      byte to write and its index 0..511
//   o_wr_nrd           one-cycle write strobe per byte
//   o_read_done        one-cycle pulse at the end of every transfer
//   o_send_cmd         command request to sd_card_cmd
//   o_cmd_select       command code (CMD17_SEL while requesting)
//   o_cmd_arg          command argument
//   i_confirm_pin      command sent and R1 captured
//   i_response_status  R1 byte, valid with i_confirm_pin
// -----------------------------------------------------------------------------
module sd_card_read_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_read,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_accept_register,
  output logic [7:0]  o_status,
  output logic [7:0]  o_data,
  output logic [31:0] o_addr,
  output logic        o_wr_nrd,
  output logic        o_read_done,
  output logic        o_send_cmd,
  output logic [2:0]  o_cmd_select,
  output logic [31:0] o_cmd_arg,
  input  logic        i_confirm_pin,
  input  logic [7:0]  i_response_status
);

  localparam logic [2:0]  CMD17_SEL     = 3'd4;
  localparam logic [16:0] TOKEN_TIMEOUT = 17'd100000;

  localparam logic [7:0]  START_TOKEN   = 8'hFE;

  localparam logic [7:0]  STATUS_BUSY    = 8'h01;
  localparam logic [7:0]  STATUS_DONE    = 8'h02;
  localparam logic [7:0]  STATUS_R1_ERR  = 8'h04;
  localparam logic [7:0]  STATUS_TIMEOUT = 8'h08;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SEND_CMD   = 3'd1;
  localparam logic [2:0] ST_WAIT_TOKEN = 3'd2;
  localparam logic [2:0] ST_READ_DATA  = 3'd3;
  localparam logic [2:0] ST_SKIP_CRC   = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;
  localparam logic [2:0] ST_ERROR      = 3'd6;

  logic [2:0]  state;
  logic [3:0]  bit_cnt;      // bits within a data byte (0..7) or CRC (0..15)
  logic [8:0]  byte_idx;     // next byte to write, 0..511
  logic [16:0] timeout_cnt;  // cycles spent hunting for the start token

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments throughout, so every register sees the
    // pre-edge values; the strobes default low and are raised only on the
    // cycle they are needed, which keeps them exactly one cycle wide.
    o_wr_nrd    <= 1'b0;
    o_read_done <= 1'b0;

    if (!i_rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 4'd0;
      byte_idx     <= 9'd0;
      timeout_cnt  <= 17'd0;
      o_status     <= 8'h00;
      o_data       <= 8'h00;
      o_addr       <= 32'd0;
      o_send_cmd   <= 1'b0;
      o_cmd_select <= 3'd0;
      o_cmd_arg    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // o_cmd_arg doubles as the latched sector address.
          if (i_start_read) begin
            o_cmd_arg    <= i_addr;
            o_cmd_select <= CMD17_SEL;
            o_send_cmd   <= 1'b1;
            o_status     <= STATUS_BUSY;
            state        <= ST_SEND_CMD;
          end
        end

        ST_SEND_CMD: begin
          // The MISO window is not inspected here, so a token-looking
          // pattern before R1 arrives cannot start a transfer.
          if (i_confirm_pin) begin
            o_send_cmd <= 1'b0;
            if (i_response_status == 8'h00) begin
              timeout_cnt <= 17'd0;
              state       <= ST_WAIT_TOKEN;
            end else begin
              o_status <= STATUS_R1_ERR;
              state    <= ST_ERROR;
            end
          end
        end

        ST_WAIT_TOKEN: begin
          // Full-window compare every cycle finds the token at any bit offset.
          if (i_accept_register == START_TOKEN) begin
            bit_cnt  <= 4'd0;
            byte_idx <= 9'd0;
            state    <= ST_READ_DATA;
          end else if (timeout_cnt == TOKEN_TIMEOUT - 17'd1) begin
            o_status <= STATUS_TIMEOUT;
            state    <= ST_ERROR;
          end else begin
            timeout_cnt <= timeout_cnt + 17'd1;
          end
        end

        ST_READ_DATA: begin
          // On the 8th bit after the token (or after the previous byte) the
          // whole window is fresh data.
          if (bit_cnt == 4'd7) begin
            bit_cnt  <= 4'd0;
            o_data   <= i_accept_register;
            o_addr   <= {23'd0, byte_idx};
            o_wr_nrd <= 1'b1;
            if (byte_idx == 9'd511) begin
              state <= ST_SKIP_CRC;
            end else begin
              byte_idx <= byte_idx + 9'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        ST_SKIP_CRC: begin
          if (bit_cnt == 4'd15) begin
            bit_cnt <= 4'd0;
            state   <= ST_DONE;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        ST_DONE: begin
          o_status    <= STATUS_DONE;
          o_read_done <= 1'b1;
          state       <= ST_IDLE;
        end

        ST_ERROR: begin
          // Error code was loaded on entry; it stays visible in IDLE.
          o_read_done <= 1'b1;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_card_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sd_card_read_ctrl
//
// Bench for sd_card_read_ctrl. Inputs are driven and outputs sampled on the
// falling clock edge. A table of read transactions is applied in a loop; the
// expected write stream is derived from the MISO bit list itself (find the
// first 0xFE window after confirm, then slice the following bits into bytes).
// Hand-written sequences cover reset, start-during-reset, mid-transfer reset
// and the token timeout.
// -----------------------------------------------------------------------------
module tb_sd_card_read_ctrl;

  localparam int TOKEN_TIMEOUT = 100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_read;
  logic [31:0] addr_in;
  logic [7:0]  acc;
  logic        confirm;
  logic [7:0]  resp;

  logic [7:0]  status;
  logic [7:0]  wdata;
  logic [31:0] waddr;
  logic        wr_nrd;
  logic        read_done;
  logic        send_cmd;
  logic [2:0]  cmd_select;
  logic [31:0] cmd_arg;

  always #5 clk = ~clk;

  sd_card_read_ctrl dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_start_read      (start_read),
    .i_addr            (addr_in),
    .i_accept_register (acc),
    .o_status          (status),
    .o_data            (wdata),
    .o_addr            (waddr),
    .o_wr_nrd          (wr_nrd),
    .o_read_done       (read_done),
    .o_send_cmd        (send_cmd),
    .o_cmd_select      (cmd_select),
    .o_cmd_arg         (cmd_arg),
    .i_confirm_pin     (confirm),
    .i_response_status (resp)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  r1;
    logic [7:0]  hist;         // MISO window while the command is pending
    int          prefix_ones;  // idle 1s before the token
    bit          spec_pattern; // 1, 0x00, 0xFE, 2048x0, 2048x1, CRC
    bit          busy_poke;    // pulse start mid-transfer
    logic [7:0]  exp_status;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit shift_en = 1'b0;
  bit q_bits[$];
  bit stream[$];

  int          wr_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          rd_n;
  int          rd_cyc;
  logic [7:0]  rd_status;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample what the last rising edge produced, then shift MISO.
  task automatic tick();
    bit b;
    @(negedge clk);
    cyc++;
    if (wr_nrd === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(waddr);
      wr_data_q.push_back(wdata);
    end
    if (read_done === 1'b1) begin
      rd_n++;
      rd_cyc    = cyc;
      rd_status = status;
    end
    if (shift_en) begin
      b   = (q_bits.size() > 0) ? q_bits.pop_front() : 1'b1;
      acc = {acc[6:0], b};
    end
  endtask

  task automatic clear_records();
    wr_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_n = 0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) stream.push_back(v[i]);
  endtask

  task automatic build_stream(input vec_t v);
    stream.delete();
    if (v.spec_pattern) begin
      stream.push_back(1'b1);
      push_byte(8'h00);
      push_byte(8'hFE);
      for (int i = 0; i < 2048; i++) stream.push_back(1'b0);
      for (int i = 0; i < 2048; i++) stream.push_back(1'b1);
    end else begin
      for (int i = 0; i < v.prefix_ones; i++) stream.push_back(1'b1);
      push_byte(8'hFE);
      for (int i = 0; i < 512; i++) push_byte(8'($urandom));
    end
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    for (int i = 0; i < 64; i++) stream.push_back(1'b1);
  endtask

  // Reference: index of the stream bit that completes the first 0xFE window,
  // starting from the window that was present when confirm was given.
  function automatic int find_token(input logic [7:0] hist);
    logic [7:0] w;
    w = hist;
    for (int i = 0; i < stream.size(); i++) begin
      w = {w[6:0], stream[i]};
      if (w == 8'hFE) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_byte(input int j, input int k);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 8; b++) r = {r[6:0], stream[j + 1 + 8 * k + b]};
    return r;
  endfunction

  task automatic do_start(input logic [31:0] a);
    start_read = 1'b1;
    addr_in    = a;
    tick();
    start_read = 1'b0;
    addr_in    = $urandom;
    check("send_cmd_rise", 64'(send_cmd), 64'd1);
    check("cmd_select", 64'(cmd_select), 64'd4);
    check("cmd_arg", 64'(cmd_arg), 64'(a));
    check("busy_status", 64'(status), 64'h01);
  endtask

  // Start, hold the command a few cycles, confirm with R1 and begin MISO.
  // Returns the cycle on which confirm was driven.
  task automatic start_and_confirm(input vec_t v, output int t0);
    clear_records();
    shift_en = 1'b0;
    acc      = v.hist;
    do_start(v.addr);
    repeat ($urandom_range(0, 4)) tick();
    check("send_cmd_hold", 64'(send_cmd), 64'd1);
    build_stream(v);
    confirm  = 1'b1;
    resp     = v.r1;
    t0       = cyc;
    q_bits   = stream;
    shift_en = 1'b1;
    tick();
    confirm = 1'b0;
    resp    = 8'($urandom);
    check("send_cmd_drop", 64'(send_cmd), 64'd0);
  endtask

  task automatic run_txn(input vec_t v);
    int t0, j, c_t, errs, budget, n;
    bit sent_again;
    start_and_confirm(v, t0);
    j          = find_token(v.hist);
    budget     = (v.r1 == 8'h00) ? stream.size() + 100 : 20;
    sent_again = 1'b0;
    while (rd_n == 0 && cyc - t0 < budget) begin
      if (v.busy_poke && cyc == t0 + 200) begin
        start_read = 1'b1;
        addr_in    = ~v.addr;
      end else begin
        start_read = 1'b0;
      end
      tick();
      if (send_cmd) sent_again = 1'b1;
    end
    start_read = 1'b0;
    check("read_done_seen", 64'(rd_n), 64'd1);
    check("final_status", 64'(rd_status), 64'(v.exp_status));
    check("no_restart", 64'(sent_again), 64'd0);
    if (v.r1 != 8'h00) begin
      check("err_no_writes", 64'(wr_cyc_q.size()), 64'd0);
      check("err_done_latency", 64'(rd_cyc - t0), 64'd2);
    end else begin
      check("token_in_stream", 64'(j >= 0), 64'd1);
      c_t = t0 + j + 1;
      n   = (wr_cyc_q.size() < 512) ? wr_cyc_q.size() : 512;
      check("write_count", 64'(wr_cyc_q.size()), 64'd512);
      errs = 0;
      for (int k = 0; k < n; k++) begin
        if (wr_addr_q[k] !== 32'(k) || wr_data_q[k] !== exp_byte(j, k) ||
            wr_cyc_q[k] != c_t + 8 * k + 9)
          errs++;
      end
      check("write_mismatches", 64'(errs), 64'd0);
      check("read_done_after_last_write", 64'(rd_cyc - (c_t + 8 * 511 + 9)), 64'd17);
      if (v.spec_pattern && n == 512)
        check("spec_bytes", {32'd0, wr_data_q[0], wr_data_q[255], wr_data_q[256], wr_data_q[511]},
              64'h0000_0000_0000_FFFF);
      if (v.busy_poke) check("cmd_arg_kept", 64'(cmd_arg), 64'(v.addr));
    end
    repeat (3) tick();
    check("status_held", 64'(status), 64'(v.exp_status));
  endtask

  vec_t vecs[6];

  initial begin
    int  t0;
    bit  flag;
    vec_t rv;

    vecs[0] = '{32'h0000_0010, 8'h00, 8'h00, 0, 1'b1, 1'b0, 8'h02};
    vecs[1] = '{$urandom, 8'h05, 8'hFF, 0, 1'b0, 1'b0, 8'h04};
    vecs[2] = '{$urandom, 8'h00, 8'hFF, 3, 1'b0, 1'b0, 8'h02};
    vecs[3] = '{$urandom, 8'h00, 8'hFE, 5, 1'b0, 1'b0, 8'h02};
    vecs[4] = '{$urandom, 8'h80, 8'h00, 0, 1'b0, 1'b0, 8'h04};
    vecs[5] = '{$urandom, 8'h00, 8'hFF, int'($urandom_range(0, 40)), 1'b0, 1'b1, 8'h02};

    rst_n      = 1'b0;
    start_read = 1'b0;
    addr_in    = $urandom;
    acc        = 8'hFF;
    confirm    = 1'b0;
    resp       = 8'h00;
    clear_records();

    // Reset held three cycles with a start pulse inside it.
    tick();
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    tick();
    check("rst_outs_a", {34'd0, status, wdata, wr_nrd, read_done, send_cmd, cmd_select}, 64'd0);
    check("rst_addr_arg", {waddr, cmd_arg}, 64'd0);

    // Start coinciding with the last reset cycle is dropped.
    start_read = 1'b1;
    tick();
    rst_n      = 1'b1;
    start_read = 1'b0;
    flag       = 1'b0;
    repeat (4) begin
      tick();
      if (send_cmd) flag = 1'b1;
    end
    check("start_in_reset_ignored", 64'(flag), 64'd0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset in the middle of the data phase, at byte 100.
    rv = '{$urandom, 8'h00, 8'hFF, 2, 1'b0, 1'b0, 8'h02};
    start_and_confirm(rv, t0);
    while (wr_cyc_q.size() < 101 && cyc - t0 < 3000) tick();
    check("reached_byte100", 64'(wr_cyc_q.size()), 64'd101);
    rst_n = 1'b0;
    tick();
    check("mid_rst_outs_a", {34'd0, status, wdata, wr_nrd, read_done, send_cmd, cmd_select}, 64'd0);
    check("mid_rst_addr_arg", {waddr, cmd_arg}, 64'd0);
    tick();
    rst_n = 1'b1;
    flag  = 1'b0;
    repeat (600) begin
      tick();
      if (send_cmd) flag = 1'b1;
    end
    check("no_writes_after_reset", 64'(wr_cyc_q.size()), 64'd101);
    check("no_done_after_reset", 64'(rd_n), 64'd0);
    check("idle_after_reset", 64'(flag), 64'd0);
    run_txn('{$urandom, 8'h00, 8'hFF, 7, 1'b0, 1'b0, 8'h02});

    // Token never arrives: MISO stays high after confirm.
    rv = '{$urandom, 8'h00, 8'hFF, 0, 1'b0, 1'b0, 8'h08};
    clear_records();
    shift_en = 1'b0;
    acc      = 8'hFF;
    do_start(rv.addr);
    confirm = 1'b1;
    resp    = 8'h00;
    t0      = cyc;
    q_bits.delete();
    shift_en = 1'b1;
    tick();
    confirm = 1'b0;
    while (rd_n == 0 && cyc - t0 < TOKEN_TIMEOUT + 50) tick();
    check("timeout_seen", 64'(rd_n), 64'd1);
    check("timeout_status", 64'(rd_status), 64'h08);
    check("timeout_cycle_window",
          64'((rd_cyc - t0) >= TOKEN_TIMEOUT && (rd_cyc - t0) <= TOKEN_TIMEOUT + 3), 64'd1);
    check("timeout_no_writes", 64'(wr_cyc_q.size()), 64'd0);
    repeat (3) tick();
    check("timeout_status_held", 64'(status), 64'h08);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
